// File: rtl/pc_source_unit.sv
// PC source select and PC register: N_SRC-way target mux, (conditional) load, alignment trap to EXC_VECTOR; optional PC_TRACE_EN redirect counter.
// Latency: one cycle from an accepted load to the new pc_out, pc_prev, bad_addr and misalign_exc values.
// Backpressure: none; each load is accepted on the edge where it is presented.
module pc_source_unit #(
    parameter int                DATA_W       = 32,
    parameter int                N_SRC        = 8,
    parameter int                SEL_W        = 3,
    parameter logic [DATA_W-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_W-1:0] EXC_VECTOR   = DATA_W'(32'h0000_00FC),
    parameter int                ALIGN_CHECK  = 1,
    parameter int                CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        selector,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic                    pc_write,
    input  logic                    pc_write_cond,
    input  logic                    cond_true,
    output logic [DATA_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       pc_prev,
    output logic                    misalign_exc,
    output logic [DATA_W-1:0]       bad_addr
`ifdef PC_TRACE_EN
    ,
    output logic [CNT_W-1:0]        redirect_cnt
`endif
);

    logic [DATA_W-1:0] tgt;
    logic [DATA_W-1:0] next_pc;
    logic              load;
    logic              misaligned;

    // Out-of-range selectors fall through to the last source.
    always_comb begin
        tgt = src_data[(N_SRC-1)*DATA_W +: DATA_W];
        for (int i = 0; i < N_SRC - 1; i++) begin
            if (selector == SEL_W'(i)) begin
                tgt = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign load       = pc_write | (pc_write_cond & cond_true);
    assign misaligned = (ALIGN_CHECK != 0) && (tgt[1:0] != 2'b00);
    assign next_pc    = misaligned ? EXC_VECTOR : tgt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out       <= RESET_VECTOR;
            pc_prev      <= '0;
            bad_addr     <= '0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            if (load) begin
                pc_out       <= next_pc;
                pc_prev      <= pc_out;
                misalign_exc <= misaligned;
                if (misaligned) begin
                    bad_addr <= tgt;
                end
            end
        end
    end

`ifdef PC_TRACE_EN
    // Any load that does not land on the fall-through address counts, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt <= '0;
        end else if (load && (next_pc != pc_out + DATA_W'(4)) && (redirect_cnt != '1)) begin
            redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_source_unit.sv
// Bench for pc_source_unit: vector table, hand sequences and randomized run against a behavioural model.
module tb_pc_source_unit;

    localparam int NS = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      selector;
    logic [NS*32-1:0] src_data;
    logic            pc_write, pc_write_cond, cond_true;
    logic [31:0]     src [NS];

    logic [31:0] pc_out, pc_prev, bad_addr;
    logic        misalign_exc;
    logic [31:0] na_pc_out, na_pc_prev, na_bad_addr;
    logic        na_misalign_exc;
`ifdef PC_TRACE_EN
    logic [1:0]  redirect_cnt, na_redirect_cnt;
`endif

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NS; i++) src_data[i*32 +: 32] = src[i];
    end

    pc_source_unit #(.DATA_W(32), .N_SRC(NS), .SEL_W(3), .RESET_VECTOR(32'h0),
                     .EXC_VECTOR(32'hFC), .ALIGN_CHECK(1), .CNT_W(2)) u_dut (
        .clk(clk), .reset(reset), .selector(selector), .src_data(src_data),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
        .pc_out(pc_out), .pc_prev(pc_prev), .misalign_exc(misalign_exc), .bad_addr(bad_addr)
`ifdef PC_TRACE_EN
        , .redirect_cnt(redirect_cnt)
`endif
    );

    pc_source_unit #(.DATA_W(32), .N_SRC(NS), .SEL_W(3), .RESET_VECTOR(32'h0),
                     .EXC_VECTOR(32'hFC), .ALIGN_CHECK(0), .CNT_W(2)) u_na (
        .clk(clk), .reset(reset), .selector(selector), .src_data(src_data),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
        .pc_out(na_pc_out), .pc_prev(na_pc_prev), .misalign_exc(na_misalign_exc),
        .bad_addr(na_bad_addr)
`ifdef PC_TRACE_EN
        , .redirect_cnt(na_redirect_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    // Reference state: m_* for the checking instance, n_* for the unchecked one.
    logic [31:0] m_pc, m_prev, m_bad, n_pc, n_prev;
    logic        m_exc;
    int          m_cnt, n_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] s, input logic w,
                         input logic wc, input logic ct);
        reset = r; selector = s; pc_write = w; pc_write_cond = wc; cond_true = ct;
    endtask

    task automatic model_step();
        int          slot;
        logic [31:0] t, np;
        logic        ld, mis;
        slot = (int'(selector) >= NS) ? NS - 1 : int'(selector);
        t    = src[slot];
        ld   = pc_write | (pc_write_cond & cond_true);
        if (reset) begin
            m_pc = 0; m_prev = 0; m_bad = 0; m_exc = 0; m_cnt = 0;
            n_pc = 0; n_prev = 0; n_cnt = 0;
        end else if (ld) begin
            mis = (t[1:0] != 2'b00);
            np  = mis ? 32'hFC : t;
            if (np != m_pc + 32'd4 && m_cnt < 3) m_cnt++;
            if (t != n_pc + 32'd4 && n_cnt < 3) n_cnt++;
            m_prev = m_pc; m_pc = np; m_exc = mis;
            if (mis) m_bad = t;
            n_prev = n_pc; n_pc = t;
        end else begin
            m_exc = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_to(input logic [31:0] v);
        for (int i = 0; i < NS; i++) src[i] = 32'h2000_0000 + 32'(i) * 32'h10;
        src[0] = v;
        drive(0, 3'd0, 1, 0, 0);
        tick();
    endtask

    typedef struct packed {
        logic        r;
        logic [2:0]  sel;
        logic        w, wc, ct;
        logic [31:0] val;
        logic [31:0] e_pc, e_prev;
        logic        e_exc;
        logic [31:0] e_bad;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'h4,   32'h0,   32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h4,   32'h4,   32'h0,   1'b0, 32'h0};
        tbl[2]  = '{1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 32'h40,  32'h40,  32'h4,   1'b0, 32'h0};
        tbl[3]  = '{1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h40,  32'h4,   1'b0, 32'h0};
        tbl[4]  = '{1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h100, 32'h40,  1'b0, 32'h0};
        tbl[5]  = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 32'h200, 32'h100, 32'h40,  1'b0, 32'h0};
        tbl[6]  = '{1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 32'h300, 32'h300, 32'h100, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 32'h102, 32'hFC,  32'h300, 1'b1, 32'h102};
        tbl[8]  = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 32'h103, 32'hFC,  32'hFC,  1'b1, 32'h103};
        tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,   32'hFC,  32'hFC,  1'b0, 32'h103};
        tbl[10] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 32'h500, 32'h500, 32'hFC,  1'b0, 32'h103};
        tbl[11] = '{1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 32'h500, 32'h500, 32'h500, 1'b0, 32'h103};
        tbl[12] = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 32'h7,   32'hFC,  32'h500, 1'b1, 32'h7};
        tbl[13] = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'h9,   32'h0,   32'h0,   1'b0, 32'h0};

        for (int i = 0; i < NS; i++) src[i] = 32'h0;
        m_pc = 0; m_prev = 0; m_bad = 0; m_exc = 0; m_cnt = 0;
        n_pc = 0; n_prev = 0; n_cnt = 0;
        drive(1, 3'd0, 0, 0, 0);
        tick(); tick();

        // Table: selected source carries the value, the rest hold distinct aligned fillers.
        for (int k = 0; k < 14; k++) begin
            int slot;
            slot = (int'(tbl[k].sel) >= NS) ? NS - 1 : int'(tbl[k].sel);
            for (int i = 0; i < NS; i++) src[i] = 32'h1000_0000 + 32'(i) * 32'h10;
            src[slot] = tbl[k].val;
            drive(tbl[k].r, tbl[k].sel, tbl[k].w, tbl[k].wc, tbl[k].ct);
            tick();
            check($sformatf("tbl%0d pc_out", k), pc_out, tbl[k].e_pc);
            check($sformatf("tbl%0d pc_prev", k), pc_prev, tbl[k].e_prev);
            check($sformatf("tbl%0d misalign_exc", k), 32'(misalign_exc), 32'(tbl[k].e_exc));
            check($sformatf("tbl%0d bad_addr", k), bad_addr, tbl[k].e_bad);
        end

        // Alignment check disabled: odd target is taken as-is, no pulse.
        load_to(32'h1);
        check("align_on pc_out", pc_out, 32'hFC);
        check("align_on exc", 32'(misalign_exc), 32'd1);
        check("align_off pc_out", na_pc_out, 32'h1);
        check("align_off exc", 32'(na_misalign_exc), 32'd0);
        check("align_off bad_addr", na_bad_addr, 32'h0);

`ifdef PC_TRACE_EN
        drive(1, 3'd0, 0, 0, 0);
        tick();
        check("cnt reset", 32'(redirect_cnt), 32'd0);
        load_to(32'h4);
        load_to(32'h8);
        check("cnt sequential", 32'(redirect_cnt), 32'd0);
        load_to(32'h40);
        load_to(32'h80);
        load_to(32'h10);
        check("cnt three jumps", 32'(redirect_cnt), 32'd3);
        load_to(32'h20);
        check("cnt saturated", 32'(redirect_cnt), 32'd3);
`endif

        // Randomized run against the model.
        for (int c = 0; c < 400; c++) begin
            logic [2:0] s;
            for (int i = 0; i < NS; i++) begin
                src[i] = $urandom;
                if ($urandom_range(0, 3) != 0) src[i][1:0] = 2'b00;
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NS; i++) src[i] = m_pc + 32'd4;
            end
            s = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 31) == 0), s, ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            check("rnd pc_out", pc_out, m_pc);
            check("rnd pc_prev", pc_prev, m_prev);
            check("rnd misalign_exc", 32'(misalign_exc), 32'(m_exc));
            check("rnd bad_addr", bad_addr, m_bad);
            check("rnd na pc_out", na_pc_out, n_pc);
            check("rnd na pc_prev", na_pc_prev, n_prev);
            check("rnd na exc", 32'(na_misalign_exc), 32'd0);
`ifdef PC_TRACE_EN
            check("rnd cnt", 32'(redirect_cnt), 32'(m_cnt));
            check("rnd na cnt", 32'(na_redirect_cnt), 32'(n_cnt));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
